onchip_memory2_arbiter: RTL and testbench
=========================================

Name: onchip_memory2_arbiter

Overview:
- Two-master arbiter that shares the single-port 32-bit on-chip RAM (51200 words, 16-bit word address, 4 byte lanes, 1-cycle read latency) between a CPU data master and a DMA master.
- Sits between the two Avalon-MM masters and the RAM's s1 slave.
- Issues at most one RAM access per cycle and grants by capped-hold round-robin.
- Routes read data back with a per-master readdatavalid, and screens out-of-range addresses.

Parameters:
- DEPTH, 51200, number of valid 32-bit words; word addresses >= DEPTH are out of range.
- MAX_HOLD, 4, maximum consecutive grants to one master while the other is waiting (>=1; 1 = strict alternation).
- OOR_DATA, 32'h0000_0000, read data returned for out-of-range reads.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; one clock, synchronous, active-high
- m0_address  in  16  master 0 word address
- m0_byteenable  in  4  master 0 byte lanes
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  32  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  32  master 0 read data
- m0_readdatavalid  out  1  master 0 read data strobe
- m1_*  same set as m0_*  master 1 (DMA)
- mem_address  out  16  to RAM address
- mem_byteenable  out  4  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  32  to RAM writedata
- mem_clken  out  1  to RAM clken; tied 1
- mem_readdata  in  32  from RAM readdata, valid 1 cycle after the address cycle

Behaviour:
- reqX = mX_read | mX_write. If mX_read and mX_write are both high, it is treated as a write; no readdatavalid is produced.
- Arbitration is combinational per cycle:
  - Exactly one requester: that master wins.
  - Both requesting: winner = last if hold_cnt < MAX_HOLD, else the other master.
- mX_waitrequest = reqX & ~winX. It is 0 when the master is not requesting. During reset both waitrequests are 1.
- An access is accepted in the cycle where reqX=1 and waitrequest=0. Accepted-access fields drive mem_* combinationally from the winner's inputs.
- mem_chipselect = 1 on any accepted access. mem_write = accepted write & in-range.
- An out-of-range write is accepted (no stall) and dropped: mem_write=0, mem_chipselect=0.
- With no request, mem_chipselect=0 and mem_write=0. mem_address, mem_byteenable and mem_writedata hold the m0 values.
- State registers (updated on each accepted access):
  - last (1 bit), hold_cnt (saturating at MAX_HOLD), rd_pend, rd_owner, rd_oor.
  - If winner == last: hold_cnt <= min(hold_cnt+1, MAX_HOLD). Otherwise last <= winner and hold_cnt <= 1.
  - hold_cnt counts all consecutive grants, contested or not.
  - Idle cycles leave last and hold_cnt unchanged.
- Read return:
  - An accepted read sets rd_pend=1, rd_owner=winner, rd_oor=(address>=DEPTH) for the next cycle. In that next cycle mX_readdatavalid=1 for X=rd_owner only.
  - mX_readdata = rd_oor ? OOR_DATA : mem_readdata. It is combinational from the RAM output and broadcast to both masters; it is meaningful only with valid.
  - Fixed latency: exactly 1 cycle after acceptance. Back-to-back reads are accepted every cycle.
  - A write accepted in the cycle a previous read's data returns does not disturb that return.
- Reset values: last=1, hold_cnt=MAX_HOLD (so m0 wins the first contest), rd_pend=0, both readdatavalid=0, mem_chipselect=0, mem_write=0.
- Reset mid-operation: a read accepted in the cycle before reset asserts produces no readdatavalid. No access is accepted while reset=1.
- Address compare is on the full 16-bit word address: 51199 is in range, 51200..65535 are out of range.

Test Plan:
- Single master: m0 writes 0xA5A5_1234 to addr 10 with be=4'b0011, then reads addr 10 -> waitrequest=0 on both cycles; mem_write pulses once; m0_readdatavalid one cycle after the read with readdata[15:0]=0x1234; m1_readdatavalid stays 0.
- Contention, MAX_HOLD=4, both masters reading continuously from reset -> grant order m0,m0,m0,m0,m1,m1,m1,m1,m0...; the loser's waitrequest=1 in every contested cycle; each readdatavalid goes to the correct owner with that owner's data.
- MAX_HOLD=1, both writing distinct addresses -> strict alternation m0,m1,m0...; RAM content shows all writes landed exactly once.
- Out of range: m1 writes addr 51200, then reads 51200 and 51199 -> the write is accepted with mem_write=0; read 51200 returns OOR_DATA with valid; read 51199 returns RAM data.
- Reset mid-read: m0 read accepted, reset asserted the next cycle -> m0_readdatavalid stays 0; after release, the first contested cycle grants m0.
- Read+write together on m0 -> treated as a write; no readdatavalid; a following read returns the written data.

Source files
------------

// File: rtl/onchip_memory2_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port on-chip RAM.
// Capped-hold round-robin grant, one RAM access per cycle, fixed 1-cycle read return.
module onchip_memory2_arbiter #(
  parameter int unsigned DEPTH    = 51200,
  parameter int unsigned MAX_HOLD = 4,
  parameter logic [31:0] OOR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [15:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,

  input  logic [15:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,

  output logic [15:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata
);

  localparam int unsigned HoldW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  logic             last_q, last_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;
  logic             rd_oor_q, rd_oor_d;

  logic        req0, req1;
  logic        winner;
  logic        accept;
  logic        win0, win1;
  logic [15:0] acc_address;
  logic [3:0]  acc_byteenable;
  logic [31:0] acc_writedata;
  logic        acc_write;
  logic        acc_read;
  logic        acc_oor;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // With no request the winner defaults to m0 so the mem_* fields idle on m0's inputs.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = (hold_cnt_q < HoldMax) ? last_q : ~last_q;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  assign accept = (req0 | req1) & ~reset;
  assign win0   = accept & ~winner;
  assign win1   = accept & winner;

  assign m0_waitrequest = reset | (req0 & ~win0);
  assign m1_waitrequest = reset | (req1 & ~win1);

  always_comb begin
    if (winner) begin
      acc_address    = m1_address;
      acc_byteenable = m1_byteenable;
      acc_writedata  = m1_writedata;
      acc_write      = m1_write;
      acc_read       = m1_read & ~m1_write;
    end else begin
      acc_address    = m0_address;
      acc_byteenable = m0_byteenable;
      acc_writedata  = m0_writedata;
      acc_write      = m0_write;
      acc_read       = m0_read & ~m0_write;
    end
  end

  assign acc_oor = 32'(acc_address) >= DEPTH;

  // Out-of-range writes are acknowledged but never reach the RAM.
  assign mem_address    = acc_address;
  assign mem_byteenable = acc_byteenable;
  assign mem_writedata  = acc_writedata;
  assign mem_chipselect = accept & ~(acc_write & acc_oor);
  assign mem_write      = accept & acc_write & ~acc_oor;
  assign mem_clken      = 1'b1;

  always_comb begin
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    rd_oor_d   = rd_oor_q;
    if (accept) begin
      if (winner == last_q) begin
        hold_cnt_d = (hold_cnt_q >= HoldMax) ? HoldMax : hold_cnt_q + HoldW'(1);
      end else begin
        last_d     = winner;
        hold_cnt_d = HoldW'(1);
      end
      rd_pend_d = acc_read;
      if (acc_read) begin
        rd_owner_d = winner;
        rd_oor_d   = acc_oor;
      end
    end
  end

  // Reset state makes m0 win the first contest (last=1 with the hold cap reached).
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= 1'b1;
      hold_cnt_q <= HoldMax;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

  // Gated by reset so a read accepted just before reset never returns.
  assign m0_readdatavalid = rd_pend_q & ~reset & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q & ~reset & rd_owner_q;
  assign m0_readdata      = rd_oor_q ? OOR_DATA : mem_readdata;
  assign m1_readdata      = rd_oor_q ? OOR_DATA : mem_readdata;

`ifndef SYNTHESIS
  a_one_grant : assert property (@(posedge clk) !(win0 && win1));
  a_one_valid : assert property (@(posedge clk) !(m0_readdatavalid && m1_readdatavalid));
  a_write_cs  : assert property (@(posedge clk) mem_write |-> mem_chipselect);
  a_hold_cap  : assert property (@(posedge clk) disable iff (reset) hold_cnt_q <= HoldMax);
`endif

endmodule

// File: tb/tb_onchip_memory2_arbiter.sv
// Randomised plus directed bench for onchip_memory2_arbiter; two instances (MAX_HOLD 4 and 1)
// share stimulus and are checked every cycle against a behavioural model with a shadow memory.
module tb_onchip_memory2_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;

  logic        a_m0_waitrequest, a_m1_waitrequest, a_m0_readdatavalid, a_m1_readdatavalid;
  logic [31:0] a_m0_readdata, a_m1_readdata, a_mem_writedata, a_mem_readdata;
  logic [15:0] a_mem_address;
  logic [3:0]  a_mem_byteenable;
  logic        a_mem_chipselect, a_mem_write, a_mem_clken;

  logic        b_m0_waitrequest, b_m1_waitrequest, b_m0_readdatavalid, b_m1_readdatavalid;
  logic [31:0] b_m0_readdata, b_m1_readdata, b_mem_writedata, b_mem_readdata;
  logic [15:0] b_mem_address;
  logic [3:0]  b_mem_byteenable;
  logic        b_mem_chipselect, b_mem_write, b_mem_clken;

  onchip_memory2_arbiter u_dut_a (
    .clk(clk), .reset(rst),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_m0_waitrequest),
    .m0_readdata(a_m0_readdata), .m0_readdatavalid(a_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_m1_waitrequest),
    .m1_readdata(a_m1_readdata), .m1_readdatavalid(a_m1_readdatavalid),
    .mem_address(a_mem_address), .mem_byteenable(a_mem_byteenable),
    .mem_chipselect(a_mem_chipselect), .mem_write(a_mem_write),
    .mem_writedata(a_mem_writedata), .mem_clken(a_mem_clken), .mem_readdata(a_mem_readdata)
  );

  onchip_memory2_arbiter #(.MAX_HOLD(1)) u_dut_b (
    .clk(clk), .reset(rst),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_m0_waitrequest),
    .m0_readdata(b_m0_readdata), .m0_readdatavalid(b_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_m1_waitrequest),
    .m1_readdata(b_m1_readdata), .m1_readdatavalid(b_m1_readdatavalid),
    .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
    .mem_chipselect(b_mem_chipselect), .mem_write(b_mem_write),
    .mem_writedata(b_mem_writedata), .mem_clken(b_mem_clken), .mem_readdata(b_mem_readdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ram_a [65536];
  logic [31:0] ram_b [65536];
  int          wcnt_b [65536];
  logic [31:0] shadow [2][65536];
  bit          m_last [2];
  int          m_hold [2];
  bit          m_pend [2];
  bit          m_owner [2];
  logic [31:0] m_data [2];

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-port RAM models: 1-cycle read latency, byte-lane writes.
  always @(posedge clk) begin
    if (a_mem_chipselect) begin
      if (a_mem_write) begin
        for (int l = 0; l < 4; l++)
          if (a_mem_byteenable[l]) ram_a[a_mem_address][8*l +: 8] <= a_mem_writedata[8*l +: 8];
      end else begin
        a_mem_readdata <= ram_a[a_mem_address];
      end
    end
    if (b_mem_chipselect) begin
      if (b_mem_write) begin
        wcnt_b[b_mem_address] <= wcnt_b[b_mem_address] + 1;
        for (int l = 0; l < 4; l++)
          if (b_mem_byteenable[l]) ram_b[b_mem_address][8*l +: 8] <= b_mem_writedata[8*l +: 8];
      end else begin
        b_mem_readdata <= ram_b[b_mem_address];
      end
    end
  end

  task automatic model_step(input int k, input int mh, input logic w0, input logic w1,
                            input logic cs, input logic we, input logic ck, input logic rv0,
                            input logic rv1, input logic [15:0] ad, input logic [3:0] be,
                            input logic [31:0] wd, input logic [31:0] rd0,
                            input logic [31:0] rd1);
    string p;
    bit rq0, rq1, any, win, isw, isr, oor;
    logic [15:0] ea;
    logic [3:0]  eb;
    logic [31:0] ew;
    p = (k == 0) ? "A" : "B";
    chk({p, ".mem_clken"}, 32'(ck), 32'd1);
    if (rst) begin
      chk({p, ".m0_waitrequest_rst"}, 32'(w0), 32'd1);
      chk({p, ".m1_waitrequest_rst"}, 32'(w1), 32'd1);
      chk({p, ".mem_chipselect_rst"}, 32'(cs), 32'd0);
      chk({p, ".mem_write_rst"}, 32'(we), 32'd0);
      chk({p, ".m0_readdatavalid_rst"}, 32'(rv0), 32'd0);
      chk({p, ".m1_readdatavalid_rst"}, 32'(rv1), 32'd0);
      m_last[k] = 1'b1;
      m_hold[k] = mh;
      m_pend[k] = 1'b0;
      return;
    end
    rq0 = m0_read | m0_write;
    rq1 = m1_read | m1_write;
    any = rq0 | rq1;
    if (rq0 && rq1) win = (m_hold[k] < mh) ? m_last[k] : !m_last[k];
    else            win = rq1;
    ea  = win ? m1_address : m0_address;
    eb  = win ? m1_byteenable : m0_byteenable;
    ew  = win ? m1_writedata : m0_writedata;
    isw = win ? m1_write : m0_write;
    isr = any && !isw;
    oor = int'(ea) >= 51200;
    chk({p, ".m0_waitrequest"}, 32'(w0), 32'(rq0 && win));
    chk({p, ".m1_waitrequest"}, 32'(w1), 32'(rq1 && !win));
    chk({p, ".mem_chipselect"}, 32'(cs), 32'(any && !(isw && oor)));
    chk({p, ".mem_write"}, 32'(we), 32'(any && isw && !oor));
    chk({p, ".mem_address"}, 32'(ad), 32'(ea));
    chk({p, ".mem_byteenable"}, 32'(be), 32'(eb));
    chk({p, ".mem_writedata"}, wd, ew);
    chk({p, ".m0_readdatavalid"}, 32'(rv0), 32'(m_pend[k] && !m_owner[k]));
    chk({p, ".m1_readdatavalid"}, 32'(rv1), 32'(m_pend[k] && m_owner[k]));
    if (m_pend[k]) begin
      chk({p, ".m0_readdata"}, rd0, m_data[k]);
      chk({p, ".m1_readdata"}, rd1, m_data[k]);
    end
    if (any) begin
      if (win == m_last[k]) begin
        m_hold[k] = (m_hold[k] + 1 > mh) ? mh : m_hold[k] + 1;
      end else begin
        m_last[k] = win;
        m_hold[k] = 1;
      end
      if (isw && !oor)
        for (int l = 0; l < 4; l++)
          if (eb[l]) shadow[k][ea][8*l +: 8] = ew[8*l +: 8];
    end
    m_pend[k] = isr;
    if (isr) begin
      m_owner[k] = win;
      m_data[k]  = oor ? 32'h0 : shadow[k][ea];
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 4, a_m0_waitrequest, a_m1_waitrequest, a_mem_chipselect, a_mem_write,
               a_mem_clken, a_m0_readdatavalid, a_m1_readdatavalid, a_mem_address,
               a_mem_byteenable, a_mem_writedata, a_m0_readdata, a_m1_readdata);
    model_step(1, 1, b_m0_waitrequest, b_m1_waitrequest, b_mem_chipselect, b_mem_write,
               b_mem_clken, b_m0_readdatavalid, b_m1_readdatavalid, b_mem_address,
               b_mem_byteenable, b_mem_writedata, b_m0_readdata, b_m1_readdata);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic setm0(input logic r, input logic w, input logic [15:0] a, input logic [3:0] b,
                       input logic [31:0] d);
    m0_read = r; m0_write = w; m0_address = a; m0_byteenable = b; m0_writedata = d;
  endtask

  task automatic setm1(input logic r, input logic w, input logic [15:0] a, input logic [3:0] b,
                       input logic [31:0] d);
    m1_read = r; m1_write = w; m1_address = a; m1_byteenable = b; m1_writedata = d;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(3))
      0:       return 16'($urandom_range(15));
      1:       return 16'(51195 + $urandom_range(9));
      2:       return 16'hFFFF;
      default: return 16'($urandom_range(40));
    endcase
  endfunction

  logic [0:9] pat_a;
  logic [0:9] pat_b;

  initial begin
    rst = 1'b1;
    setm0(0, 0, 16'h0, 4'h0, 32'h0);
    setm1(0, 0, 16'h0, 4'h0, 32'h0);
    a_mem_readdata = 32'h0;
    b_mem_readdata = 32'h0;
    for (int i = 0; i < 65536; i++) begin
      ram_a[i] = init_word(i);
      ram_b[i] = init_word(i);
      shadow[0][i] = init_word(i);
      shadow[1][i] = init_word(i);
      wcnt_b[i] = 0;
    end
    cycle();
    cycle();
    rst = 1'b0;

    // Single master write then read-back.
    setm0(0, 1, 16'd10, 4'b0011, 32'hA5A5_1234);
    #2;
    chk("sm.wr_waitrequest", 32'(a_m0_waitrequest), 32'd0);
    chk("sm.wr_mem_write", 32'(a_mem_write), 32'd1);
    cycle();
    setm0(1, 0, 16'd10, 4'hF, 32'h0);
    #2;
    chk("sm.rd_waitrequest", 32'(a_m0_waitrequest), 32'd0);
    chk("sm.rd_mem_write", 32'(a_mem_write), 32'd0);
    cycle();
    idle();
    #2;
    chk("sm.m0_readdatavalid", 32'(a_m0_readdatavalid), 32'd1);
    chk("sm.readdata_lo", 32'(a_m0_readdata[15:0]), 32'h1234);
    chk("sm.m1_readdatavalid", 32'(a_m1_readdatavalid), 32'd0);
    cycle();

    // Contention from reset: 1 in the pattern means m1 is granted.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    pat_a = 10'b0000111100;
    pat_b = 10'b0101010101;
    for (int i = 0; i < 10; i++) begin
      setm0(1, 0, 16'(100 + i), 4'hF, 32'h0);
      setm1(1, 0, 16'(200 + i), 4'hF, 32'h0);
      #2;
      chk("A.contest_m0_wait", 32'(a_m0_waitrequest), 32'(pat_a[i]));
      chk("A.contest_m1_wait", 32'(a_m1_waitrequest), 32'(!pat_a[i]));
      chk("B.contest_m0_wait", 32'(b_m0_waitrequest), 32'(pat_b[i]));
      chk("B.contest_m1_wait", 32'(b_m1_waitrequest), 32'(!pat_b[i]));
      cycle();
    end
    idle();
    cycle();

    // Strict alternation of writes on the MAX_HOLD=1 instance.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      setm0(0, 1, 16'(300 + c / 2), 4'hF, 32'hC0DE_0000 | 32'(c / 2));
      setm1(0, 1, 16'(400 + c / 2), 4'hF, 32'hD00D_0000 | 32'(c / 2));
      cycle();
    end
    idle();
    cycle();
    for (int k = 0; k < 4; k++) begin
      chk("B.alt_m0_data", ram_b[300 + k], 32'hC0DE_0000 | 32'(k));
      chk("B.alt_m1_data", ram_b[400 + k], 32'hD00D_0000 | 32'(k));
      chk("B.alt_m0_count", 32'(wcnt_b[300 + k]), 32'd1);
      chk("B.alt_m1_count", 32'(wcnt_b[400 + k]), 32'd1);
    end

    // Out-of-range boundary on m1.
    setm1(0, 1, 16'd51199, 4'hF, 32'h5151_9999);
    cycle();
    setm1(0, 1, 16'd51200, 4'hF, 32'hBAD0_BAD0);
    #2;
    chk("oor.wr_waitrequest", 32'(a_m1_waitrequest), 32'd0);
    chk("oor.wr_mem_write", 32'(a_mem_write), 32'd0);
    chk("oor.wr_chipselect", 32'(a_mem_chipselect), 32'd0);
    cycle();
    setm1(1, 0, 16'd51200, 4'hF, 32'h0);
    cycle();
    setm1(1, 0, 16'd51199, 4'hF, 32'h0);
    #2;
    chk("oor.rd_valid", 32'(a_m1_readdatavalid), 32'd1);
    chk("oor.rd_data", a_m1_readdata, 32'h0);
    chk("oor.rd_m0_valid", 32'(a_m0_readdatavalid), 32'd0);
    cycle();
    idle();
    #2;
    chk("inr.rd_valid", 32'(a_m1_readdatavalid), 32'd1);
    chk("inr.rd_data", a_m1_readdata, 32'h5151_9999);
    cycle();

    // Reset right after an accepted read.
    setm0(1, 0, 16'd5, 4'hF, 32'h0);
    cycle();
    idle();
    rst = 1'b1;
    #2;
    chk("rstrd.A_valid", 32'(a_m0_readdatavalid), 32'd0);
    chk("rstrd.B_valid", 32'(b_m0_readdatavalid), 32'd0);
    cycle();
    rst = 1'b0;
    setm0(1, 0, 16'd6, 4'hF, 32'h0);
    setm1(1, 0, 16'd7, 4'hF, 32'h0);
    #2;
    chk("rstrd.m0_wins", 32'(a_m0_waitrequest), 32'd0);
    chk("rstrd.m1_waits", 32'(a_m1_waitrequest), 32'd1);
    cycle();
    idle();
    cycle();

    // Read and write together is a write.
    setm0(1, 1, 16'd20, 4'hF, 32'hDEAD_BEEF);
    #2;
    chk("rw.mem_write", 32'(a_mem_write), 32'd1);
    cycle();
    setm0(1, 0, 16'd20, 4'hF, 32'h0);
    #2;
    chk("rw.no_valid", 32'(a_m0_readdatavalid), 32'd0);
    cycle();
    idle();
    #2;
    chk("rw.readback_valid", 32'(a_m0_readdatavalid), 32'd1);
    chk("rw.readback_data", a_m0_readdata, 32'hDEAD_BEEF);
    cycle();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(99) == 0);
      setm0($urandom_range(2) == 0, $urandom_range(3) == 0, pick_addr(),
            4'($urandom_range(15)), $urandom);
      setm1($urandom_range(2) == 0, $urandom_range(3) == 0, pick_addr(),
            4'($urandom_range(15)), $urandom);
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
